// File: rtl/cond_pkg.sv
// Shared constants for the ALU flag interface: condition codes, flag bit
// positions and ALU opcodes, plus the output-buffer state type.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ROR = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator over {N,Z,C,V}; shared with the
// branch unit.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves pass unassigned (no latch).
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural NZCV flag register with opcode-masked updates, plus a
// one-entry buffered condition evaluator with valid/ready handshake.
module flag_cond_unit
    import cond_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flagWe,
    input  logic [1:0] aluOp,
    input  logic       N,
    input  logic       Z,
    input  logic       C,
    input  logic       V,
    input  logic       condValid,
    input  logic [3:0] cond,
    output logic       condReady,
    output logic       execValid,
    output logic       exec,
    input  logic       execAck,
    output logic       carry,
    output logic [3:0] flags
);

    logic [3:0] flag_q;
    logic [3:0] next_flags;
    logic       next_pass;
    logic       accept;
    logic       exec_q;
    buf_state_t state;

    // Logical ops leave C and V alone; rotate also refreshes C.
    always_comb begin
        next_flags = flag_q;
        if (flagWe) begin
            next_flags[FLAG_N] = N;
            next_flags[FLAG_Z] = Z;
            if (aluOp != ALU_AND)
                next_flags[FLAG_C] = C;
            if (aluOp == ALU_ADD || aluOp == ALU_SUB)
                next_flags[FLAG_V] = V;
        end
    end

    // Evaluated on next_flags so a same-cycle flag write is forwarded.
    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (next_flags),
        .pass  (next_pass)
    );

    assign condReady = (state == ST_EMPTY) || execAck;
    assign accept    = condValid && condReady;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst)
            flag_q <= 4'b0000;
        else
            flag_q <= next_flags;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_EMPTY;
            exec_q <= 1'b0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        exec_q <= next_pass;
                        state  <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept)
                        exec_q <= next_pass;
                    else if (execAck)
                        state <= ST_EMPTY;
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign execValid = (state == ST_FULL);
    assign exec      = exec_q;
    assign flags     = flag_q;
    assign carry     = flag_q[FLAG_C];

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: directed literal checks from the
// test plan, then randomized traffic compared against a behavioural model.
module tb_flag_cond_unit;
    import cond_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flagWe = 1'b0;
    logic [1:0] aluOp = 2'b00;
    logic       N = 1'b0, Z = 1'b0, C = 1'b0, V = 1'b0;
    logic       condValid = 1'b0;
    logic [3:0] cond = 4'd0;
    logic       condReady;
    logic       execValid;
    logic       exec;
    logic       execAck = 1'b0;
    logic       carry;
    logic [3:0] flags;

    int pass_cnt = 0;
    int total_cnt = 0;

    flag_cond_unit dut (
        .clk       (clk),
        .rst       (rst),
        .flagWe    (flagWe),
        .aluOp     (aluOp),
        .N         (N),
        .Z         (Z),
        .C         (C),
        .V         (V),
        .condValid (condValid),
        .cond      (cond),
        .condReady (condReady),
        .execValid (execValid),
        .exec      (exec),
        .execAck   (execAck),
        .carry     (carry),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference condition rule: pairs of codes share a predicate, odd code inverts.
    function automatic bit model_pass(input logic [3:0] c, input bit n, input bit z,
                                      input bit cy, input bit v);
        bit base;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    // Behavioural model: flag bits and the buffered result.
    bit m_n = 0, m_z = 0, m_c = 0, m_v = 0;
    bit m_valid = 0, m_exec = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_n, m_z, m_c, m_v} = 4'b0000;
            m_valid = 0;
            m_exec  = 0;
        end else begin
            bit ready, take;
            ready = !m_valid || execAck;
            take  = condValid && ready;
            if (flagWe) begin
                m_n = N;
                m_z = Z;
                if (aluOp != 2'b10) m_c = C;
                if (aluOp <= 2'b01) m_v = V;
            end
            if (take) begin
                m_valid = 1;
                m_exec  = model_pass(cond, m_n, m_z, m_c, m_v);
            end else if (m_valid && execAck) begin
                m_valid = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_flags", flags, {m_n, m_z, m_c, m_v});
        check("model_carry", {3'b0, carry}, {3'b0, m_c});
        check("model_execValid", {3'b0, execValid}, {3'b0, m_valid});
        check("model_condReady", {3'b0, condReady}, {3'b0, !m_valid || execAck});
        if (m_valid)
            check("model_exec", {3'b0, exec}, {3'b0, m_exec});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [1:0] op, input logic [3:0] nzcv);
        flagWe = 1'b1;
        aluOp  = op;
        {N, Z, C, V} = nzcv;
    endtask

    bit exp_sweep [16] = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0};

    initial begin
        #12 rst = 1'b0;
        #1;
        check("reset_flags", flags, 4'b0000);
        check("reset_carry", {3'b0, carry}, 4'd0);
        check("reset_execValid", {3'b0, execValid}, 4'd0);
        check("reset_condReady", {3'b0, condReady}, 4'd1);

        // EQ on cleared flags fails.
        condValid = 1'b1; cond = COND_EQ;
        step();
        condValid = 1'b0;
        check("first_execValid", {3'b0, execValid}, 4'd1);
        check("first_exec", {3'b0, exec}, 4'd0);
        execAck = 1'b1;
        step();
        execAck = 1'b0;

        // Sub updates all four; and keeps C and V.
        set_flags(ALU_SUB, 4'b0110);
        step();
        check("sub_flags", flags, 4'b0110);
        check("sub_carry", {3'b0, carry}, 4'd1);
        set_flags(ALU_AND, 4'b1001);
        step();
        flagWe = 1'b0;
        check("and_flags", flags, 4'b1010);

        // Forwarding: request sees the same-cycle flag write.
        set_flags(ALU_ADD, 4'b0100);
        condValid = 1'b1; cond = COND_EQ;
        step();
        flagWe = 1'b0;
        check("fwd_eq_exec", {3'b0, exec}, 4'd1);
        cond = COND_NE; execAck = 1'b1;
        step();
        check("fwd_ne_exec", {3'b0, exec}, 4'd0);
        condValid = 1'b0;
        step();
        execAck = 1'b0;

        // Full condition sweep with N=V=1.
        set_flags(ALU_ADD, 4'b1001);
        step();
        flagWe = 1'b0;
        execAck = 1'b1;
        for (int c = 0; c < 16; c++) begin
            condValid = 1'b1;
            cond = 4'(c);
            step();
            check($sformatf("sweep_cond%0d", c), {3'b0, exec}, {3'b0, exp_sweep[c]});
        end
        condValid = 1'b0;
        step();
        execAck = 1'b0;

        // Stall: buffered EQ (fails), pending EQ held off while flags change.
        condValid = 1'b1; cond = COND_EQ;
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_flags(ALU_ADD, 4'b0100);
            #1;
            check("stall_condReady", {3'b0, condReady}, 4'd0);
            check("stall_exec", {3'b0, exec}, 4'd0);
            step();
            flagWe = 1'b0;
        end
        check("stall_exec_after_flagwe", {3'b0, exec}, 4'd0);
        execAck = 1'b1;
        #1;
        check("ack_condReady", {3'b0, condReady}, 4'd1);
        step();
        check("b2b_execValid", {3'b0, execValid}, 4'd1);
        check("b2b_exec", {3'b0, exec}, 4'd1);
        condValid = 1'b0; execAck = 1'b0;
        step();

        // Randomized traffic; the model compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            flagWe    = ($urandom_range(0, 2) == 0);
            aluOp     = 2'($urandom_range(0, 3));
            {N, Z, C, V} = 4'($urandom_range(0, 15));
            condValid = ($urandom_range(0, 9) < 7);
            cond      = 4'($urandom_range(0, 15));
            execAck   = ($urandom_range(0, 1) == 1);
            step();
        end

        // Asynchronous reset while FULL, mid-cycle.
        flagWe = 1'b0; execAck = 1'b0;
        set_flags(ALU_ADD, 4'b1111);
        condValid = 1'b1; cond = COND_AL;
        step();
        flagWe = 1'b0; condValid = 1'b0;
        check("pre_rst_execValid", {3'b0, execValid}, 4'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_execValid", {3'b0, execValid}, 4'd0);
        check("async_rst_flags", flags, 4'b0000);
        check("async_rst_carry", {3'b0, carry}, 4'd0);
        check("async_rst_condReady", {3'b0, condReady}, 4'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
